spi_inst_dec_reg: RTL and testbench
===================================

Name: spi_inst_dec_reg

Overview:
ST7735R-compatible command decoder and register file sitting between the SPI byte receiver (spi_slave) and the frame-buffer SRAM controller. It consumes received bytes with no D/C line, so command versus parameter is inferred from byte position. It holds the CASET/RASET window registers and the display-on flag, and issues single-cycle requests to the SRAM side for clear, write-address set and pixel write.

Parameters:
DEFAULT_XE, 16'd127, column-end value after reset or SWRESET (128-wide panel)
DEFAULT_YE, 16'd159, row-end value after reset or SWRESET (160-tall panel)

Ports:
i_clk  input  1  system clock (27 MHz); all logic is on the rising edge
i_rst  input  1  asynchronous, active-high reset
i_spi_data  input  8  received byte; valid only in the cycle i_spi_rxdone=1
i_spi_csreleased  input  1  one-cycle pulse when SPI CS deasserts (frame end)
i_spi_rxdone  input  1  one-cycle pulse: i_spi_data holds a new byte
o_pixel_data  output  16  last assembled RGB565 pixel
o_col_addr  output  32  {XS[15:0], XE[15:0]}
o_row_addr  output  32  {YS[15:0], YE[15:0]}
o_sram_clr_req  output  1  one-cycle pulse: clear entire SRAM
o_sram_write_req  output  1  one-cycle pulse: write o_pixel_data
o_sram_waddr_set_req  output  1  one-cycle pulse: load write pointer from the col/row window
o_dispOn  output  1  display enable level

Behaviour:
- Reset values:
  - o_pixel_data = 0
  - o_col_addr = {16'd0, DEFAULT_XE}
  - o_row_addr = {16'd0, DEFAULT_YE}
  - all request outputs = 0
  - o_dispOn = 0
  - FSM in S_CMD
- FSM states: S_CMD, S_PARAM, S_PIX_HI, S_PIX_LO. Bytes are processed only on i_spi_rxdone.
- S_CMD: the received byte is the command.
  - 0x00 NOP: ignored; stay in S_CMD.
  - 0x01 SWRESET: pulse o_sram_clr_req; restore col/row to reset values; o_dispOn=0.
  - 0x28 DISPOFF: o_dispOn=0.
  - 0x29 DISPON: o_dispOn=1.
  - 0x2A CASET / 0x2B RASET: go to S_PARAM and expect 4 bytes.
  - 0x36 MADCTL / 0x3A COLMOD: go to S_PARAM, expect 1 byte, and discard it.
  - 0x2C RAMWR: pulse o_sram_waddr_set_req; go to S_PIX_HI.
  - Any other byte: ignored (treated as a zero-parameter command).
- S_PARAM: bytes are shifted into a 32-bit shadow register, MSB first (S[15:8], S[7:0], E[15:8], E[7:0]).
  - On the 4th byte, o_col_addr (CASET) or o_row_addr (RASET) is updated atomically in the next cycle. Outputs never show a partial update.
  - After the last expected byte, return to S_CMD.
- S_PIX_HI: the byte is latched as the high byte; go to S_PIX_LO.
- S_PIX_LO:
  - o_pixel_data = {hi, byte}.
  - o_sram_write_req pulses in the same cycle o_pixel_data first shows the new value (1-cycle latency from rxdone).
  - Return to S_PIX_HI. RAMWR streams pixels indefinitely until frame end.
- Request outputs: registered, high for exactly one clock per event. Reaching the next rxdone takes at least 2 clocks at the SPI byte rate, so requests never merge.
- i_spi_csreleased: from any state, return to S_CMD.
  - An incomplete CASET/RASET parameter set is discarded; registers keep old values.
  - A dangling pixel high byte is discarded with no write.
  - If csreleased and rxdone occur in the same cycle, the byte is processed first, then the FSM goes to S_CMD.
- No window or pixel-count checking is done here; address wrap is the SRAM controller's job.
- Asserting i_rst mid-stream forces all reset values immediately, with no pending pulses.

Test Plan:
- Reset then NOP (0x00) -> no request pulses; o_col_addr=0x0000007F, o_row_addr=0x0000009F, o_dispOn=0.
- SWRESET (0x01) after DISPON (0x29) -> o_dispOn goes 1 then 0; exactly one o_sram_clr_req pulse; addresses at default.
- Fill sequence: 2A 00 00 00 00, 2B 00 00 00 0A, 2C, then 11 × {FF,FF} -> col=0x00000000, row=0x0000000A; one waddr_set_req pulse; 11 write_req pulses each with o_pixel_data=0xFFFF.
- After CS release: 2A 00 00 00 0A, 2B 00 00 00 00, 2C, {F0,0F}×11 -> col=0x0000000A, row=0x00000000; 11 writes of 0xF00F.
- CASET 00 05 then CS release -> o_col_addr unchanged; the next byte is decoded as a command.
- RAMWR, then one byte, then CS release -> no write_req; the next frame's first byte is treated as a command.

Source files
------------

// File: rtl/spi_inst_dec_reg_if.sv
// Byte-stream and SRAM-request bundle between the SPI receiver, the command
// decoder and the frame-buffer controller.
interface spi_inst_dec_reg_if;
  logic [7:0]  i_spi_data;
  logic        i_spi_csreleased;
  logic        i_spi_rxdone;
  logic [15:0] o_pixel_data;
  logic [31:0] o_col_addr;
  logic [31:0] o_row_addr;
  logic        o_sram_clr_req;
  logic        o_sram_write_req;
  logic        o_sram_waddr_set_req;
  logic        o_dispOn;

  modport slave (
    input  i_spi_data, i_spi_csreleased, i_spi_rxdone,
    output o_pixel_data, o_col_addr, o_row_addr,
    output o_sram_clr_req, o_sram_write_req, o_sram_waddr_set_req, o_dispOn
  );

  modport master (
    output i_spi_data, i_spi_csreleased, i_spi_rxdone,
    input  o_pixel_data, o_col_addr, o_row_addr,
    input  o_sram_clr_req, o_sram_write_req, o_sram_waddr_set_req, o_dispOn
  );
endinterface

// File: rtl/spi_inst_dec_reg.sv
// ST7735R-style command decoder: infers command/parameter/pixel bytes from
// their position in the CS frame and holds the address window and display flag.
module spi_inst_dec_reg #(
  parameter logic [15:0] DEFAULT_XE = 16'd127,
  parameter logic [15:0] DEFAULT_YE = 16'd159
) (
  input  logic              i_clk,
  input  logic              i_rst,
  spi_inst_dec_reg_if.slave bus
);

  localparam logic [7:0] CMD_NOP     = 8'h00;
  localparam logic [7:0] CMD_SWRESET = 8'h01;
  localparam logic [7:0] CMD_DISPOFF = 8'h28;
  localparam logic [7:0] CMD_DISPON  = 8'h29;
  localparam logic [7:0] CMD_CASET   = 8'h2A;
  localparam logic [7:0] CMD_RASET   = 8'h2B;
  localparam logic [7:0] CMD_RAMWR   = 8'h2C;
  localparam logic [7:0] CMD_MADCTL  = 8'h36;
  localparam logic [7:0] CMD_COLMOD  = 8'h3A;

  localparam logic [31:0] COL_RST = {16'd0, DEFAULT_XE};
  localparam logic [31:0] ROW_RST = {16'd0, DEFAULT_YE};

  typedef enum logic [1:0] {S_CMD, S_PARAM, S_PIX_HI, S_PIX_LO} state_t;
  typedef enum logic [1:0] {P_CASET, P_RASET, P_SKIP} param_t;

  state_t      r_state;
  param_t      r_param;
  logic [1:0]  r_param_cnt;
  // The 4th byte completes the word directly, so only the first three are kept.
  logic [23:0] r_shadow;
  logic [7:0]  r_pix_hi;
  logic [15:0] r_pixel_data;
  logic [31:0] r_col_addr;
  logic [31:0] r_row_addr;
  logic        r_clr_req;
  logic        r_write_req;
  logic        r_waddr_req;
  logic        r_disp_on;

  logic [7:0]  w_byte;
  logic [31:0] w_param_word;

  assign w_byte       = bus.i_spi_data;
  assign w_param_word = {r_shadow, w_byte};

  // NOTE: every register here is written with <= so all updates in a cycle see
  // the pre-edge values; blocking assignments would create order-dependent logic.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_CMD;
      r_param      <= P_SKIP;
      r_param_cnt  <= 2'd0;
      r_shadow     <= 24'd0;
      r_pix_hi     <= 8'd0;
      r_pixel_data <= 16'd0;
      r_col_addr   <= COL_RST;
      r_row_addr   <= ROW_RST;
      r_clr_req    <= 1'b0;
      r_write_req  <= 1'b0;
      r_waddr_req  <= 1'b0;
      r_disp_on    <= 1'b0;
    end else begin
      r_clr_req   <= 1'b0;
      r_write_req <= 1'b0;
      r_waddr_req <= 1'b0;

      if (bus.i_spi_rxdone) begin
        unique case (r_state)
          S_CMD: begin
            case (w_byte)
              CMD_NOP: ;
              CMD_SWRESET: begin
                r_clr_req  <= 1'b1;
                r_col_addr <= COL_RST;
                r_row_addr <= ROW_RST;
                r_disp_on  <= 1'b0;
              end
              CMD_DISPOFF: r_disp_on <= 1'b0;
              CMD_DISPON:  r_disp_on <= 1'b1;
              CMD_CASET: begin
                r_state     <= S_PARAM;
                r_param     <= P_CASET;
                r_param_cnt <= 2'd0;
              end
              CMD_RASET: begin
                r_state     <= S_PARAM;
                r_param     <= P_RASET;
                r_param_cnt <= 2'd0;
              end
              CMD_MADCTL, CMD_COLMOD: begin
                r_state     <= S_PARAM;
                r_param     <= P_SKIP;
                r_param_cnt <= 2'd0;
              end
              CMD_RAMWR: begin
                r_waddr_req <= 1'b1;
                r_state     <= S_PIX_HI;
              end
              default: ;
            endcase
          end

          S_PARAM: begin
            if (r_param == P_SKIP) begin
              r_state <= S_CMD;
            end else begin
              r_shadow    <= {r_shadow[15:0], w_byte};
              r_param_cnt <= r_param_cnt + 2'd1;
              // Window registers change only once the full word has arrived.
              if (r_param_cnt == 2'd3) begin
                if (r_param == P_CASET) r_col_addr <= w_param_word;
                else                    r_row_addr <= w_param_word;
                r_state <= S_CMD;
              end
            end
          end

          S_PIX_HI: begin
            r_pix_hi <= w_byte;
            r_state  <= S_PIX_LO;
          end

          S_PIX_LO: begin
            r_pixel_data <= {r_pix_hi, w_byte};
            r_write_req  <= 1'b1;
            r_state      <= S_PIX_HI;
          end

          default: r_state <= S_CMD;
        endcase
      end

      // Frame end wins over any state change made by a byte in the same cycle.
      if (bus.i_spi_csreleased) r_state <= S_CMD;
    end
  end

  assign bus.o_pixel_data         = r_pixel_data;
  assign bus.o_col_addr           = r_col_addr;
  assign bus.o_row_addr           = r_row_addr;
  assign bus.o_sram_clr_req       = r_clr_req;
  assign bus.o_sram_write_req     = r_write_req;
  assign bus.o_sram_waddr_set_req = r_waddr_req;
  assign bus.o_dispOn             = r_disp_on;

endmodule

// File: tb/tb_spi_inst_dec_reg.sv
// Scoreboard bench for spi_inst_dec_reg: expected request pulses are queued as
// bytes are driven and matched by a negedge monitor.
module tb_spi_inst_dec_reg;

  typedef enum logic [1:0] {E_NONE, E_CLR, E_WADDR, E_WR} exp_t;

  typedef struct {
    int unsigned due;
    logic [15:0] pix;
  } exp_ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int unsigned cyc = 0;
  int          n_checks = 0;
  int          n_errors = 0;

  exp_ev_t wr_q[$];
  exp_ev_t clr_q[$];
  exp_ev_t waddr_q[$];

  spi_inst_dec_reg_if bus();

  spi_inst_dec_reg #(
    .DEFAULT_XE(16'd127),
    .DEFAULT_YE(16'd159)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Drives one byte for a single clock, then one idle clock (SPI byte rate).
  task automatic send_byte(input logic [7:0] b, input logic cs = 1'b0,
                           input exp_t kind = E_NONE, input logic [15:0] pix = 16'h0);
    exp_ev_t ev;
    @(negedge clk);
    bus.i_spi_data       = b;
    bus.i_spi_rxdone     = 1'b1;
    bus.i_spi_csreleased = cs;
    ev.due = cyc + 1;
    ev.pix = pix;
    case (kind)
      E_CLR:   clr_q.push_back(ev);
      E_WADDR: waddr_q.push_back(ev);
      E_WR:    wr_q.push_back(ev);
      default: ;
    endcase
    @(negedge clk);
    bus.i_spi_data       = 8'h00;
    bus.i_spi_rxdone     = 1'b0;
    bus.i_spi_csreleased = 1'b0;
    @(negedge clk);
  endtask

  task automatic cs_release();
    @(negedge clk);
    bus.i_spi_csreleased = 1'b1;
    @(negedge clk);
    bus.i_spi_csreleased = 1'b0;
  endtask

  task automatic send_window(input logic [7:0] cmd, input logic [31:0] w);
    send_byte(cmd);
    for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
  endtask

  task automatic send_pixels(input logic [7:0] hi, input logic [7:0] lo, input int n);
    for (int i = 0; i < n; i++) begin
      send_byte(hi);
      send_byte(lo, 1'b0, E_WR, {hi, lo});
    end
  endtask

  // Monitor: every request pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_ev_t e;
    if (!rst) begin
      if (bus.o_sram_write_req) begin
        if (wr_q.size() == 0) check("wr_unexpected", 1, 0);
        else begin
          e = wr_q.pop_front();
          check("wr_cycle", cyc, e.due);
          check("wr_pixel", {16'h0, bus.o_pixel_data}, {16'h0, e.pix});
        end
      end
      if (bus.o_sram_clr_req) begin
        if (clr_q.size() == 0) check("clr_unexpected", 1, 0);
        else begin
          e = clr_q.pop_front();
          check("clr_cycle", cyc, e.due);
        end
      end
      if (bus.o_sram_waddr_set_req) begin
        if (waddr_q.size() == 0) check("waddr_unexpected", 1, 0);
        else begin
          e = waddr_q.pop_front();
          check("waddr_cycle", cyc, e.due);
        end
      end
    end
  end

  initial begin
    bus.i_spi_data       = 8'h00;
    bus.i_spi_rxdone     = 1'b0;
    bus.i_spi_csreleased = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    check("rst_col",  bus.o_col_addr, 32'h0000007F);
    check("rst_row",  bus.o_row_addr, 32'h0000009F);
    check("rst_disp", bus.o_dispOn, 0);
    check("rst_pix",  bus.o_pixel_data, 0);
    check("rst_reqs", {bus.o_sram_clr_req, bus.o_sram_write_req, bus.o_sram_waddr_set_req}, 0);

    // NOP changes nothing
    send_byte(8'h00);
    check("nop_col",  bus.o_col_addr, 32'h0000007F);
    check("nop_row",  bus.o_row_addr, 32'h0000009F);
    check("nop_disp", bus.o_dispOn, 0);

    // CASET becomes visible only after the 4th parameter byte
    send_byte(8'h2A);
    send_byte(8'h00);
    send_byte(8'h01);
    send_byte(8'h00);
    check("caset_partial", bus.o_col_addr, 32'h0000007F);
    send_byte(8'h02);
    check("caset_full", bus.o_col_addr, 32'h00010002);

    // DISPON then SWRESET
    send_byte(8'h29);
    check("dispon", bus.o_dispOn, 1);
    send_byte(8'h01, 1'b0, E_CLR);
    check("swreset_disp", bus.o_dispOn, 0);
    check("swreset_col",  bus.o_col_addr, 32'h0000007F);
    check("swreset_row",  bus.o_row_addr, 32'h0000009F);
    cs_release();

    // Fill frame 1
    send_window(8'h2A, 32'h00000000);
    send_window(8'h2B, 32'h0000000A);
    send_byte(8'h2C, 1'b0, E_WADDR);
    send_pixels(8'hFF, 8'hFF, 11);
    cs_release();
    check("f1_col", bus.o_col_addr, 32'h00000000);
    check("f1_row", bus.o_row_addr, 32'h0000000A);

    // Fill frame 2
    send_window(8'h2A, 32'h0000000A);
    send_window(8'h2B, 32'h00000000);
    send_byte(8'h2C, 1'b0, E_WADDR);
    send_pixels(8'hF0, 8'h0F, 11);
    cs_release();
    check("f2_col", bus.o_col_addr, 32'h0000000A);
    check("f2_row", bus.o_row_addr, 32'h00000000);

    // Truncated CASET is dropped; the next byte is a command
    send_byte(8'h2A);
    send_byte(8'h00);
    send_byte(8'h05);
    cs_release();
    check("trunc_col", bus.o_col_addr, 32'h0000000A);
    send_byte(8'h29);
    check("trunc_next_cmd", bus.o_dispOn, 1);

    // Dangling pixel high byte is dropped; next byte is a command
    send_byte(8'h2C, 1'b0, E_WADDR);
    send_byte(8'hFF);
    cs_release();
    send_byte(8'h28);
    check("dangle_next_cmd", bus.o_dispOn, 0);

    // MADCTL/COLMOD swallow exactly one byte; unknown bytes are ignored
    send_byte(8'h29);
    send_byte(8'h36);
    send_byte(8'h2A);
    send_byte(8'h28);
    check("madctl_skip", bus.o_dispOn, 0);
    send_byte(8'h3A);
    send_byte(8'h29);
    check("colmod_skip", bus.o_dispOn, 0);
    send_byte(8'h55);
    send_byte(8'h29);
    check("unknown_cmd", bus.o_dispOn, 1);

    // Last pixel byte coincides with CS release: write happens, then S_CMD
    send_byte(8'h2C, 1'b0, E_WADDR);
    send_byte(8'hAB);
    send_byte(8'hCD, 1'b1, E_WR, 16'hABCD);
    send_byte(8'h28);
    check("cs_same_cycle_cmd", bus.o_dispOn, 0);
    send_byte(8'h29);

    // Asynchronous reset mid-stream: a pending pixel byte never writes
    send_byte(8'h2C, 1'b0, E_WADDR);
    send_byte(8'h12);
    @(negedge clk);
    bus.i_spi_data   = 8'h34;
    bus.i_spi_rxdone = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("arst_col",  bus.o_col_addr, 32'h0000007F);
    check("arst_row",  bus.o_row_addr, 32'h0000009F);
    check("arst_disp", bus.o_dispOn, 0);
    check("arst_pix",  bus.o_pixel_data, 0);
    @(negedge clk);
    bus.i_spi_rxdone = 1'b0;
    bus.i_spi_data   = 8'h00;
    check("arst_reqs", {bus.o_sram_clr_req, bus.o_sram_write_req, bus.o_sram_waddr_set_req}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    check("pending_wr",    wr_q.size(), 0);
    check("pending_clr",   clr_q.size(), 0);
    check("pending_waddr", waddr_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
